// File: rtl/worldmap_level_switch.sv
// Level-select stage for the world-map datapath: muxes one of N world-map ROM
// outputs onto the video path and the maze-bot path. A CPU level change is
// applied to video only on frame_start, and to the bot path only while the
// bot is idle. Progress and illegal selects are reported back to software.
module worldmap_level_switch #(
    parameter int unsigned N_LEVELS      = 8,
    parameter int unsigned SEL_W         = 3,
    parameter int unsigned PIX_W         = 2,
    parameter int unsigned DEFAULT_LEVEL = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          lsel_req,
    input  logic                      frame_start,
    input  logic                      bot_idle,
    input  logic [N_LEVELS*PIX_W-1:0] vid_pix_in,
    input  logic [N_LEVELS*PIX_W-1:0] bot_pix_in,
    output logic [PIX_W-1:0]          vid_pix_out,
    output logic [PIX_W-1:0]          bot_pix_out,
    output logic [SEL_W-1:0]          vid_level,
    output logic [SEL_W-1:0]          bot_level,
    output logic                      switch_pending,
    output logic                      switch_done,
    output logic                      bad_sel
);

    // Level count widened by one bit so N_LEVELS == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   NLEV_EXT = (SEL_W+1)'(N_LEVELS);
    localparam logic [SEL_W-1:0] DEF_LVL  = SEL_W'(DEFAULT_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q;
    logic [SEL_W-1:0]   req_q;
    logic [SEL_W-1:0]   tgt_q;
    logic [SEL_W-1:0]   tgt_d;
    logic [SEL_W-1:0]   vid_level_q;
    logic [SEL_W-1:0]   bot_level_q;
    logic               vid_cmt_q;
    logic               bot_cmt_q;
    logic               pending_q;
    logic               done_q;
    logic               bad_sel_q;
    logic [PIX_W-1:0]   vid_pix_q;
    logic [PIX_W-1:0]   bot_pix_q;
    logic [PIX_W-1:0]   vid_pix_d;
    logic [PIX_W-1:0]   bot_pix_d;
    logic               capture_c;
    logic               in_range_c;

    // Request capture decode: any change of the CPU register starts a new switch.
    always_comb begin
        capture_c  = (lsel_req != req_q);
        in_range_c = ({1'b0, lsel_req} < NLEV_EXT);
        tgt_d      = in_range_c ? lsel_req : DEF_LVL;
    end

    // Switch controller: capture has priority over every state, commits are
    // gated per path, DONE is entered only once both registered flags are set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= DEF_LVL;
            tgt_q       <= DEF_LVL;
            vid_level_q <= DEF_LVL;
            bot_level_q <= DEF_LVL;
            vid_cmt_q   <= 1'b0;
            bot_cmt_q   <= 1'b0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
            bad_sel_q   <= 1'b0;
        end else if (capture_c) begin
            req_q     <= lsel_req;
            tgt_q     <= tgt_d;
            vid_cmt_q <= 1'b0;
            bot_cmt_q <= 1'b0;
            state_q   <= ST_ARMED;
            pending_q <= 1'b1;
            done_q    <= 1'b0;
            if (!in_range_c) begin
                bad_sel_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pending_q <= 1'b0;
                    done_q    <= 1'b0;
                end
                ST_ARMED: begin
                    pending_q <= 1'b1;
                    done_q    <= 1'b0;
                    if (frame_start && !vid_cmt_q) begin
                        vid_level_q <= tgt_q;
                        vid_cmt_q   <= 1'b1;
                    end
                    if (bot_idle && !bot_cmt_q) begin
                        bot_level_q <= tgt_q;
                        bot_cmt_q   <= 1'b1;
                    end
                    if (vid_cmt_q && bot_cmt_q) begin
                        state_q   <= ST_DONE;
                        pending_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    pending_q <= 1'b0;
                    done_q    <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pending_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // Pixel select: constant-index slices only, so an out-of-range level can never be sliced.
    always_comb begin
        vid_pix_d = '0;
        bot_pix_d = '0;
        for (int unsigned k = 0; k < N_LEVELS; k++) begin
            if (vid_level_q == SEL_W'(k)) begin
                vid_pix_d = vid_pix_in[k*PIX_W +: PIX_W];
            end
            if (bot_level_q == SEL_W'(k)) begin
                bot_pix_d = bot_pix_in[k*PIX_W +: PIX_W];
            end
        end
    end

    // Pixel output registers: one clock of latency on both paths.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vid_pix_q <= '0;
            bot_pix_q <= '0;
        end else begin
            vid_pix_q <= vid_pix_d;
            bot_pix_q <= bot_pix_d;
        end
    end

    assign vid_pix_out    = vid_pix_q;
    assign bot_pix_out    = bot_pix_q;
    assign vid_level      = vid_level_q;
    assign bot_level      = bot_level_q;
    assign switch_pending = pending_q;
    assign switch_done    = done_q;
    assign bad_sel        = bad_sel_q;

endmodule

// File: tb/tb_worldmap_level_switch.sv
// Directed, table-driven bench for worldmap_level_switch with N_LEVELS=7 so
// that lsel_req=7 is an illegal select.
module tb_worldmap_level_switch;

    localparam int N  = 7;
    localparam int SW = 3;
    localparam int PW = 2;

    logic              clk;
    logic              rst;
    logic [SW-1:0]     lsel_req;
    logic              frame_start;
    logic              bot_idle;
    logic [N*PW-1:0]   vid_pix_in;
    logic [N*PW-1:0]   bot_pix_in;
    logic [PW-1:0]     vid_pix_out;
    logic [PW-1:0]     bot_pix_out;
    logic [SW-1:0]     vid_level;
    logic [SW-1:0]     bot_level;
    logic              switch_pending;
    logic              switch_done;
    logic              bad_sel;

    int n_cmp = 0;
    int n_bad = 0;

    worldmap_level_switch #(
        .N_LEVELS(N), .SEL_W(SW), .PIX_W(PW), .DEFAULT_LEVEL(0)
    ) dut (
        .clk(clk), .rst(rst), .lsel_req(lsel_req), .frame_start(frame_start),
        .bot_idle(bot_idle), .vid_pix_in(vid_pix_in), .bot_pix_in(bot_pix_in),
        .vid_pix_out(vid_pix_out), .bot_pix_out(bot_pix_out),
        .vid_level(vid_level), .bot_level(bot_level),
        .switch_pending(switch_pending), .switch_done(switch_done), .bad_sel(bad_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel; int fs; int bi;
        int vl;  int bl; int pend; int done; int bad;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(int sel, int fs, int bi, int vl, int bl, int p, int d, int b);
        vec_t v;
        v.sel = sel; v.fs = fs; v.bi = bi;
        v.vl = vl; v.bl = bl; v.pend = p; v.done = d; v.bad = b;
        tbl.push_back(v);
    endfunction

    function automatic int slice(logic [N*PW-1:0] v, int lvl);
        logic [N*PW-1:0] t;
        t = v >> (PW * lvl);
        return int'(t[PW-1:0]);
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(int idx, int vl, int bl, int p, int d, int b, int vp, int bp);
        chk("vid_level", idx, 32'(vid_level), 32'(vl));
        chk("bot_level", idx, 32'(bot_level), 32'(bl));
        chk("switch_pending", idx, 32'(switch_pending), 32'(p));
        chk("switch_done", idx, 32'(switch_done), 32'(d));
        chk("bad_sel", idx, 32'(bad_sel), 32'(b));
        chk("vid_pix_out", idx, 32'(vid_pix_out), 32'(vp));
        chk("bot_pix_out", idx, 32'(bot_pix_out), 32'(bp));
    endtask

    // One cycle: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(int sel, int fs, int bi, output int vp_exp_in, output int bp_exp_in,
                        input int vl_prev, input int bl_prev);
        @(negedge clk);
        lsel_req    = SW'(sel);
        frame_start = fs[0];
        bot_idle    = bi[0];
        vid_pix_in  = (N*PW)'($urandom);
        bot_pix_in  = (N*PW)'($urandom);
        vp_exp_in   = slice(vid_pix_in, vl_prev);
        bp_exp_in   = slice(bot_pix_in, bl_prev);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int vl_prev;
        int bl_prev;
        int vp;
        int bp;

        // Stimulus table: {lsel, frame_start, bot_idle} -> levels, pending, done, bad after the edge.
        add(0,0,0, 0,0,0,0,0);
        // frame-gated video switch 0 -> 2 with bot idle
        add(2,0,1, 0,0,1,0,0);
        add(2,0,1, 0,2,1,0,0);
        add(2,0,1, 0,2,1,0,0);
        add(2,1,0, 2,2,1,0,0);
        add(2,0,0, 2,2,0,1,0);
        add(2,0,0, 2,2,0,0,0);
        add(2,0,0, 2,2,0,0,0);
        // superseding request 3 then 5
        add(3,0,0, 2,2,1,0,0);
        add(3,1,0, 3,2,1,0,0);
        add(5,0,0, 3,2,1,0,0);
        add(5,0,1, 3,5,1,0,0);
        add(5,0,0, 3,5,1,0,0);
        add(5,1,0, 5,5,1,0,0);
        add(5,0,0, 5,5,0,1,0);
        add(5,0,0, 5,5,0,0,0);
        // out-of-range select -> default level, sticky bad_sel
        add(7,0,0, 5,5,1,0,1);
        add(7,1,1, 0,0,1,0,1);
        add(7,0,0, 0,0,0,1,1);
        add(7,0,0, 0,0,0,0,1);
        add(4,0,0, 0,0,1,0,1);
        add(4,1,1, 4,4,1,0,1);
        add(4,0,0, 4,4,0,1,1);
        add(4,0,0, 4,4,0,0,1);
        // strobes coincident with capture are ignored; commit next cycle
        add(6,1,1, 4,4,1,0,1);
        add(6,1,1, 6,6,1,0,1);
        add(6,0,0, 6,6,0,1,1);
        add(6,0,0, 6,6,0,0,1);
        // same-level request still runs ARMED/DONE
        add(1,0,0, 6,6,1,0,1);
        add(6,0,0, 6,6,1,0,1);
        add(6,1,1, 6,6,1,0,1);
        add(6,0,0, 6,6,0,1,1);
        add(6,0,0, 6,6,0,0,1);
        // capture on the would-be DONE edge suppresses that pulse
        add(2,1,1, 6,6,1,0,1);
        add(2,1,1, 2,2,1,0,1);
        add(3,0,0, 2,2,1,0,1);
        add(3,1,1, 3,3,1,0,1);
        add(3,0,0, 3,3,0,1,1);
        add(3,0,0, 3,3,0,0,1);

        // Reset held low with random inputs
        rst = 1'b1; lsel_req = '0; frame_start = 1'b0; bot_idle = 1'b0;
        vid_pix_in = '0; bot_pix_in = '0;
        #3 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lsel_req    = SW'($urandom);
            frame_start = 1'($urandom);
            bot_idle    = 1'($urandom);
            vid_pix_in  = (N*PW)'($urandom);
            bot_pix_in  = (N*PW)'($urandom);
            @(posedge clk);
            #1;
            chk_all(100 + i, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        lsel_req = '0; frame_start = 1'b0; bot_idle = 1'b0;
        rst = 1'b1;

        vl_prev = 0;
        bl_prev = 0;
        foreach (tbl[i]) begin
            step(tbl[i].sel, tbl[i].fs, tbl[i].bi, vp, bp, vl_prev, bl_prev);
            chk_all(i, tbl[i].vl, tbl[i].bl, tbl[i].pend, tbl[i].done, tbl[i].bad, vp, bp);
            vl_prev = tbl[i].vl;
            bl_prev = tbl[i].bl;
        end

        // Mid-switch asynchronous reset
        step(5, 0, 0, vp, bp, vl_prev, bl_prev);
        chk("mid_pending", 200, 32'(switch_pending), 32'd1);
        step(5, 1, 0, vp, bp, 3, 3);
        chk("mid_vid_commit", 201, 32'(vid_level), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk_all(202, 0, 0, 0, 0, 0, 0, 0);
        lsel_req = 3'd3; frame_start = 1'b0; bot_idle = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(3, 0, 0, vp, bp, 0, 0);
        chk_all(203, 0, 0, 1, 0, 0, vp, bp);
        step(3, 1, 1, vp, bp, 0, 0);
        chk_all(204, 3, 3, 1, 0, 0, vp, bp);
        step(3, 0, 0, vp, bp, 3, 3);
        chk_all(205, 3, 3, 0, 1, 0, vp, bp);
        step(3, 0, 0, vp, bp, 3, 3);
        chk_all(206, 3, 3, 0, 0, 0, vp, bp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/worldmap_level_switch.md
# worldmap_level_switch

Parametrised level-select stage for the Toad Maze world-map datapath, on the 75 MHz video/bot clock. It picks one of N world-map ROM outputs for the video path and, separately, for the maze-bot collision path. A CPU level change is applied to video only at a frame boundary, so the frame does not tear. It is applied to the bot path only while the bot is idle, so no move is evaluated against a half-switched map. It also reports switch progress and illegal selects back to software.

## Interface
- N_LEVELS, 8, number of world-map ROMs feeding the block (2..16)
- SEL_W, 3, width of level index; 2**SEL_W >= N_LEVELS
- PIX_W, 2, bits per world-map pixel
- DEFAULT_LEVEL, 0, level used after reset and substituted for out-of-range selects

- clk  in  1  75 MHz video/bot clock
- rst  in  1  asynchronous, active-low reset
- lsel_req  in  SEL_W  requested level from the CPU register; level-sensitive, may change any cycle
- frame_start  in  1  one-cycle pulse at start of vertical blank
- bot_idle  in  1  high when the maze bot is not mid-evaluation of a map read
- vid_pix_in  in  N_LEVELS*PIX_W  packed video-port ROM outputs; level k at [k*PIX_W +: PIX_W]
- bot_pix_in  in  N_LEVELS*PIX_W  packed bot-port ROM outputs, same packing
- vid_pix_out  out  PIX_W  registered selected video pixel
- bot_pix_out  out  PIX_W  registered selected bot map pixel
- vid_level  out  SEL_W  level currently driving vid_pix_out
- bot_level  out  SEL_W  level currently driving bot_pix_out
- switch_pending  out  1  a captured request is not yet committed on both paths
- switch_done  out  1  one-cycle pulse when both paths reach the target
- bad_sel  out  1  sticky: an out-of-range lsel_req was seen

## Operation
- **Request capture.**
  - Register req_q holds the last sampled lsel_req.
  - When lsel_req != req_q, load req_q <= lsel_req.
  - Load target tgt <= (lsel_req < N_LEVELS) ? lsel_req : DEFAULT_LEVEL.
  - Clear both commit flags and set switch_pending.
  - If lsel_req >= N_LEVELS, set bad_sel. bad_sel clears only on rst.
- **State machine.**
  - IDLE: switch_pending=0. Go to ARMED on capture.
  - ARMED: switch_pending=1.
    - frame_start with vid_cmt=0: vid_level <= tgt, vid_cmt <= 1.
    - bot_idle with bot_cmt=0: bot_level <= tgt, bot_cmt <= 1.
    - Both flags set (evaluated on registered values): go to DONE.
  - DONE: switch_done=1 for exactly one cycle, switch_pending=0. Return to IDLE.
- **Capture priority.** A capture in any state, including DONE, has priority.
  - Both commit flags clear and the FSM goes to ARMED.
  - A path already committed to the old target recommits at its next qualifying event.
  - A DONE pulse coincident with a capture is suppressed.
- **Same-level request.** A request equal to the current vid_level/bot_level still runs the full ARMED/DONE sequence.
- **Capture cycle.** frame_start and bot_idle are ignored in the capture cycle itself. Commits are evaluated from the following cycle against the new tgt.
- **Simultaneous commit.** frame_start and bot_idle in the same cycle commit both paths on the same edge.
- **Muxing.** Each cycle:
  - vid_pix_out <= vid_pix_in[vid_level*PIX_W +: PIX_W]
  - bot_pix_out <= bot_pix_in[bot_level*PIX_W +: PIX_W]
  - vid_level and bot_level are always < N_LEVELS; no out-of-range slice is ever indexed.
- **Reset (rst=0), asynchronous, all values:**
  - vid_pix_out = 0, bot_pix_out = 0
  - vid_level = bot_level = tgt = req_q = DEFAULT_LEVEL
  - switch_pending = 0, switch_done = 0, bad_sel = 0
  - FSM = IDLE
- **Reset release.** If lsel_req != DEFAULT_LEVEL at release, a capture occurs on the first clock edge.

## Timing
- Pixel latency is 1 clk from vid_pix_in/bot_pix_in to the outputs. The display timing generator's pixel_row/column and the colorizer input are aligned for this.
- Capture at edge E0 (lsel_req changed before E0): switch_pending=1 after E0.
- frame_start sampled high at edge Ev (Ev > E0): vid_level updates at Ev. vid_pix_out reflects the new level after Ev+1.
- Same rule for bot_idle / bot_level.
- Last commit at edge Ec: state DONE after Ec+1. switch_done high for the cycle after Ec+1. switch_pending drops at Ec+1.
- Minimum request-to-done is 2 clks, when both strobes arrive in the cycle after capture.
- No throughput limit on pixel data. One switch is outstanding at a time; a newer request supersedes an older one.

## Test plan
- **Reset values.** Hold rst=0 with random inputs → all outputs match the reset list. Release with lsel_req=0 (DEFAULT_LEVEL=0) → no pending, vid_pix_out tracks level 0 with 1-clk latency.
- **Frame-gated video switch.** lsel_req 0→2 with bot_idle=1 → bot_level=2 one cycle after capture. vid_level stays 0 until frame_start, then 2. switch_done pulses once. Level 2 pixels appear at vid_pix_out 1 clk later.
- **Superseding request.** lsel_req 1→3, then vid commits on frame_start, then lsel_req→5 before bot_idle → vid_level recommits to 5 at the next frame_start. No switch_done for 3. Exactly one switch_done, with both levels = 5.
- **Out-of-range select.** N_LEVELS=7, lsel_req=7 → bad_sel=1 and sticky. Both levels commit to DEFAULT_LEVEL. A later lsel_req=4 switches normally and bad_sel stays 1.
- **Simultaneous events.** Capture in the same cycle as frame_start and bot_idle → no commit that cycle. A second coincident pulse the next cycle commits both. switch_done fires 2 clks after capture.
- **Mid-switch reset.** Assert rst mid-ARMED → outputs immediately return to reset values. After release with lsel_req=3 → capture on the first edge, completes normally.
